pixel_compositor: RTL and testbench

PIXEL_COMPOSITOR -- requirements
Module: pixel_compositor

---
 rtl/pixel_compositor.sv | 146 ++++++++++++++
 tb/tb_pixel_compositor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_compositor.sv
// pixel_compositor: layers ship/bullet/enemy/background into one registered
// RGB stream and tallies per-frame collisions into a frame report and a
// cumulative score. Frames are delimited by one-cycle frame_start pulses.
module pixel_compositor #(
  parameter int FRAME_CNT_W = 8,
  parameter int SCORE_W     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   blank,
  input  logic                   frame_start,
  input  logic [23:0]            bg_color,
  input  logic [24:0]            ship_color,
  input  logic [24:0]            bullet_color,
  input  logic [24:0]            enemy_color,
  output logic [23:0]            rgb,
  output logic                   report_valid,
  output logic [FRAME_CNT_W-1:0] frame_hits,
  output logic                   ship_hit,
  output logic [SCORE_W-1:0]     score,
  output logic [1:0]             o_state
);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    REPORT     = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   w_counting;
  logic                   w_boundary;
  logic                   w_report;

  logic [23:0]            r_rgb;
  logic [23:0]            w_comp;
  logic [FRAME_CNT_W-1:0] r_acc_hits;
  logic                   r_acc_ship;
  logic [FRAME_CNT_W-1:0] r_frame_hits;
  logic                   r_ship_hit;
  logic [SCORE_W-1:0]     r_score;

  logic                   w_bullet_px;
  logic                   w_ship_px;
  logic [FRAME_CNT_W-1:0] w_hits_sum;
  logic                   w_ship_sum;

  // Collision pixels only count inside the visible area.
  assign w_bullet_px = bullet_color[0] & enemy_color[0] & ~blank;
  assign w_ship_px   = ship_color[0]   & enemy_color[0] & ~blank;

  // Accumulator value including this cycle, saturating at all-ones.
  assign w_hits_sum = (w_bullet_px && (r_acc_hits != '1))
                      ? r_acc_hits + FRAME_CNT_W'(1) : r_acc_hits;
  assign w_ship_sum = r_acc_ship | w_ship_px;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= WAIT_FRAME;
    else       r_state <= w_next_state;
  end

  // Next-state and control decode. A frame_start in REPORT opens a new
  // frame immediately, so REPORT repeats for the one-cycle frame that ended.
  always_comb begin
    w_next_state = r_state;
    w_counting   = 1'b0;
    w_boundary   = 1'b0;
    w_report     = 1'b0;
    case (r_state)
      WAIT_FRAME: begin
        if (frame_start) w_next_state = ACTIVE;
      end
      ACTIVE: begin
        w_counting = 1'b1;
        if (frame_start) begin
          w_boundary   = 1'b1;
          w_next_state = REPORT;
        end
      end
      REPORT: begin
        w_counting   = 1'b1;
        w_report     = 1'b1;
        w_next_state = ACTIVE;
        if (frame_start) begin
          w_boundary   = 1'b1;
          w_next_state = REPORT;
        end
      end
      default: w_next_state = WAIT_FRAME;
    endcase
  end

  // Layer priority: ship over bullet over enemy over background.
  always_comb begin
    w_comp = bg_color;
    if (ship_color[0])        w_comp = ship_color[24:1];
    else if (bullet_color[0]) w_comp = bullet_color[24:1];
    else if (enemy_color[0])  w_comp = enemy_color[24:1];
  end

  // Registered pixel output; black while idle or blanked.
  always_ff @(posedge clock) begin
    if (reset)                              r_rgb <= '0;
    else if (r_state == WAIT_FRAME || blank) r_rgb <= '0;
    else                                    r_rgb <= w_comp;
  end

  // Frame accumulators and the latched report. The boundary cycle's own hit
  // goes into the report; the next frame starts from zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc_hits   <= '0;
      r_acc_ship   <= 1'b0;
      r_frame_hits <= '0;
      r_ship_hit   <= 1'b0;
    end else if (w_boundary) begin
      r_frame_hits <= w_hits_sum;
      r_ship_hit   <= w_ship_sum;
      r_acc_hits   <= '0;
      r_acc_ship   <= 1'b0;
    end else if (w_counting) begin
      r_acc_hits   <= w_hits_sum;
      r_acc_ship   <= w_ship_sum;
    end else begin
      r_acc_hits   <= '0;
      r_acc_ship   <= 1'b0;
    end
  end

  // Score counts reported frames with at least one bullet hit, saturating.
  always_ff @(posedge clock) begin
    if (reset) r_score <= '0;
    else if (w_report && (r_frame_hits != '0) && (r_score != '1))
      r_score <= r_score + SCORE_W'(1);
  end

  assign rgb          = r_rgb;
  assign report_valid = w_report;
  assign frame_hits   = r_frame_hits;
  assign ship_hit     = r_ship_hit;
  assign score        = r_score;
  assign o_state      = r_state;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed bench for pixel_compositor: rgb expectations queued per input
// cycle, frame reports queued at each frame boundary.
module tb_pixel_compositor;

  logic        clock;
  logic        reset;
  logic        blank;
  logic        frame_start;
  logic [23:0] bg_color;
  logic [24:0] ship_color;
  logic [24:0] bullet_color;
  logic [24:0] enemy_color;
  logic [23:0] rgb;
  logic        report_valid;
  logic [7:0]  frame_hits;
  logic        ship_hit;
  logic [15:0] score;
  logic [1:0]  o_state;

  pixel_compositor #(.FRAME_CNT_W(8), .SCORE_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .blank        (blank),
    .frame_start  (frame_start),
    .bg_color     (bg_color),
    .ship_color   (ship_color),
    .bullet_color (bullet_color),
    .enemy_color  (enemy_color),
    .rgb          (rgb),
    .report_valid (report_valid),
    .frame_hits   (frame_hits),
    .ship_hit     (ship_hit),
    .score        (score),
    .o_state      (o_state)
  );

  // Clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [23:0] SHIP_RGB   = 24'hFF0000;
  localparam logic [23:0] BULLET_RGB = 24'h00FF00;
  localparam logic [23:0] ENEMY_RGB  = 24'h0000FF;
  localparam logic [23:0] BG_RGB     = 24'h123456;

  logic [23:0] exp_q[$];
  logic [8:0]  rep_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        m_wait   = 1'b1;
  logic [15:0] exp_score = '0;
  int          m_hits;
  logic        m_ship;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] model_rgb();
    if (reset || m_wait || blank) return 24'h0;
    if (ship_color[0])   return ship_color[24:1];
    if (bullet_color[0]) return bullet_color[24:1];
    if (enemy_color[0])  return enemy_color[24:1];
    return bg_color;
  endfunction

  // One clock: queue expected pixel, advance, compare pixel and any report.
  task automatic tick();
    logic [8:0] rep;
    exp_q.push_back(model_rgb());
    if (reset) m_wait = 1'b1;
    else if (frame_start) m_wait = 1'b0;
    @(posedge clock);
    #1;
    check("rgb", {8'h0, rgb}, {8'h0, exp_q.pop_front()});
    if (report_valid) begin
      if (rep_q.size() == 0) begin
        check("unexpected_report", {31'h0, report_valid}, 32'h0);
      end else begin
        rep = rep_q.pop_front();
        check("frame_hits", {24'h0, frame_hits}, {24'h0, rep[7:0]});
        check("ship_hit", {31'h0, ship_hit}, {31'h0, rep[8]});
      end
    end
  endtask

  task automatic layers(input logic s, input logic b, input logic e, input logic bl);
    ship_color   = {SHIP_RGB, s};
    bullet_color = {BULLET_RGB, b};
    enemy_color  = {ENEMY_RGB, e};
    blank        = bl;
  endtask

  // Frame boundary with idle layers; expects a report, then checks score.
  task automatic boundary(input logic [7:0] hits, input logic sh);
    rep_q.push_back({sh, hits});
    frame_start = 1'b1;
    tick();
    check("state_report", {30'h0, o_state}, 32'd2);
    frame_start = 1'b0;
    layers(0, 0, 0, 0);
    if (hits != 0) exp_score++;
    tick();
    check("score", {16'h0, score}, {16'h0, exp_score});
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    bg_color = BG_RGB;
    layers(0, 0, 0, 0);

    // Reset state.
    tick();
    tick();
    check("rst_report_valid", {31'h0, report_valid}, 32'h0);
    check("rst_frame_hits", {24'h0, frame_hits}, 32'h0);
    check("rst_ship_hit", {31'h0, ship_hit}, 32'h0);
    check("rst_score", {16'h0, score}, 32'h0);
    check("rst_state", {30'h0, o_state}, 32'd0);

    // Collisions while waiting are ignored.
    reset = 1'b0;
    layers(1, 1, 1, 0);
    tick();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("state_active", {30'h0, o_state}, 32'd1);

    // Priority: ship > bullet > enemy > bg; blank forces black, no hits.
    layers(1, 1, 1, 0); tick();   // bullet hit + ship hit
    layers(0, 1, 1, 0); tick();   // bullet hit
    layers(0, 0, 1, 0); tick();
    layers(0, 0, 0, 0); tick();
    layers(1, 1, 1, 1); tick();   // blanked, not counted
    layers(0, 0, 0, 0);
    boundary(8'd2, 1'b1);

    // Five bullet/enemy overlaps with random colors.
    for (int i = 0; i < 5; i++) begin
      ship_color   = {24'($urandom), 1'b0};
      bullet_color = {24'($urandom), 1'b1};
      enemy_color  = {24'($urandom), 1'b1};
      bg_color     = 24'($urandom);
      tick();
    end
    layers(0, 0, 0, 0);
    bg_color = BG_RGB;
    boundary(8'd5, 1'b0);

    // Random layer mix with a bench-side hit tally.
    m_hits = 0;
    m_ship = 1'b0;
    for (int i = 0; i < 24; i++) begin
      ship_color   = {24'($urandom), 1'($urandom_range(0, 1))};
      bullet_color = {24'($urandom), 1'($urandom_range(0, 1))};
      enemy_color  = {24'($urandom), 1'($urandom_range(0, 1))};
      bg_color     = 24'($urandom);
      blank        = ($urandom_range(0, 3) == 0);
      if (!blank && enemy_color[0] && bullet_color[0]) m_hits++;
      if (!blank && enemy_color[0] && ship_color[0]) m_ship = 1'b1;
      tick();
    end
    layers(0, 0, 0, 0);
    bg_color = BG_RGB;
    boundary(8'(m_hits), m_ship);

    // Saturation: 300 overlaps report 255.
    layers(0, 1, 1, 0);
    for (int i = 0; i < 300; i++) tick();
    layers(0, 0, 0, 0);
    boundary(8'd255, 1'b0);

    // Overlap only on the boundary cycle: 1 now, 0 in the next frame.
    tick();
    layers(0, 1, 1, 0);
    boundary(8'd1, 1'b0);
    tick();
    boundary(8'd0, 1'b0);

    // frame_start during REPORT: report repeats for the one-cycle frame.
    tick();
    rep_q.push_back(9'd0);
    frame_start = 1'b1;
    tick();
    layers(0, 1, 1, 0);
    boundary(8'd1, 1'b0);
    check("state_after_repeat", {30'h0, o_state}, 32'd1);

    // Reset mid-frame discards partial hits; first frame_start is silent.
    layers(0, 1, 1, 0);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    layers(0, 0, 0, 0);
    exp_score = '0;
    check("mid_rst_frame_hits", {24'h0, frame_hits}, 32'h0);
    check("mid_rst_score", {16'h0, score}, 32'h0);
    check("mid_rst_state", {30'h0, o_state}, 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("no_report_after_rst", {31'h0, report_valid}, 32'h0);
    tick();
    boundary(8'd0, 1'b0);
    tick();

    check("reports_outstanding", rep_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
